// File: rtl/fsm_serial_pkg.sv
// Shared definitions for the serial-bit FSM path (serializer and downstream stage).
//   STATE_W   : width of the serializer state encoding
//   state_t   : IDLE=0, SHIFT=1, PAR=2, GAP=3
//   GAP_CNT_W : width of the inter-word gap counter
package fsm_serial_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage : fsm_serial_pkg

// File: rtl/bit_serializer_piso_shift_reg.sv
// Parallel-in / serial-out shift register. The head bit is the bit currently
// presented on the line; each shift advances to the next bit and zero-fills.
// Ports:
//   clk   in  1      clock, posedge
//   rst   in  1      synchronous active-high reset (clears the register)
//   load  in  1      load d (has priority over shift)
//   shift in  1      advance one bit
//   d     in  WIDTH  parallel word
//   head  out 1      current head bit
module piso_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             head
);

    logic [WIDTH-1:0] r_q;

    // Shift toward the head end; the head end depends on bit order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                r_q <= {r_q[WIDTH-2:0], 1'b0};
            end else begin
                r_q <= {1'b0, r_q[WIDTH-1:1]};
            end
        end
    end

    assign head = (MSB_FIRST != 0) ? r_q[WIDTH-1] : r_q[0];

endmodule : piso_shift_reg

// File: rtl/bit_serializer.sv
// Upstream feeder for the serial-bit Moore FSM stage: accepts a parallel word
// over valid/ready and emits it one bit per clock on ser_out, followed by an
// optional parity bit and GAP_CYCLES idle-low cycles.
// Optional feature macro: PARITY_BIT_EN (adds an even-parity bit after the data).
// Ports:
//   clk       in  1      clock, posedge
//   rst       in  1      synchronous active-high reset
//   s_valid   in  1      parallel word present
//   s_ready   out 1      word can be accepted (IDLE only)
//   s_data    in  WIDTH  parallel word, sampled on the accept edge only
//   ser_out   out 1      serial bit (downstream din)
//   ser_valid out 1      ser_out carries a data or parity bit
//   ser_last  out 1      final emitted bit of the word
//   busy      out 1      any state other than IDLE
// All outputs are decoded from registered state only (Moore).
module bit_serializer
    import fsm_serial_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : (GAP_CYCLES - 1));
    // State entered once the last emitted bit of a word is done.
    localparam state_t POST_WORD = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       w_bit_cnt_nxt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic [GAP_CNT_W-1:0]   w_gap_cnt_nxt;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_head;

    // Data path: word storage and bit ordering.
    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .d     (s_data),
        .head  (w_head)
    );

`ifdef PARITY_BIT_EN
    logic r_parity;

    // Even parity of the accepted word, captured with the word itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^s_data;
        end
    end
`endif

    // State and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        s_ready       = 1'b0;
        ser_out       = 1'b0;
        ser_valid     = 1'b0;
        ser_last      = 1'b0;
        busy          = 1'b1;

        case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    w_load        = 1'b1;
                    w_bit_cnt_nxt = CNT_LOAD;
                    w_state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = w_head;
                w_shift   = 1'b1;
                if (r_bit_cnt == '0) begin
`ifdef PARITY_BIT_EN
                    w_state_nxt   = ST_PAR;
`else
                    ser_last      = 1'b1;
                    w_state_nxt   = POST_WORD;
                    w_gap_cnt_nxt = GAP_LOAD;
`endif
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                end
            end

`ifdef PARITY_BIT_EN
            ST_PAR: begin
                ser_valid     = 1'b1;
                ser_out       = r_parity;
                ser_last      = 1'b1;
                w_state_nxt   = POST_WORD;
                w_gap_cnt_nxt = GAP_LOAD;
            end
`endif

            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_CNT_W'(1);
                end
            end

            // Unreachable encodings recover to IDLE without emitting anything.
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one default instance (MSB first, one gap
// cycle) and one LSB-first / no-gap instance feeding a toggle-on-one model of
// the downstream serial FSM. Expectations adapt when PARITY_BIT_EN is defined.
module tb_bit_serializer;

`ifdef PARITY_BIT_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam int EXP_LEN = HAS_PAR ? 9 : 8;

    logic       clk;
    logic       rst;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    logic       l_s_valid;
    logic       l_s_ready;
    logic [7:0] l_s_data;
    logic       l_ser_out;
    logic       l_ser_valid;
    logic       l_ser_last;
    logic       l_busy;

    logic       cnt_clr;
    int         n_valid;
    logic       ds_dout;

    int         n_vec;
    int         n_err;

    bit_serializer #(
        .WIDTH      (8),
        .MSB_FIRST  (1),
        .GAP_CYCLES (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    bit_serializer #(
        .WIDTH      (8),
        .MSB_FIRST  (0),
        .GAP_CYCLES (0)
    ) u_dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (l_s_valid),
        .s_ready   (l_s_ready),
        .s_data    (l_s_data),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .ser_last  (l_ser_last),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of valid bits on the default instance since the last clear.
    always @(posedge clk) begin
        if (cnt_clr) n_valid <= 0;
        else if (ser_valid) n_valid <= n_valid + 1;
    end

    // Downstream stage model: dout toggles on every valid 1 bit.
    always @(posedge clk) begin
        if (rst) ds_dout <= 1'b0;
        else if (l_ser_valid && l_ser_out) ds_dout <= ~ds_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expect 8 data bits; seq lists them first-to-last from bit 7 down to bit 0.
    task automatic expect_data(input string tag, input logic [7:0] seq);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s valid%0d", tag, i), 32'(ser_valid), 1);
            check($sformatf("%s bit%0d", tag, i), 32'(ser_out), 32'(seq[7-i]));
            check($sformatf("%s last%0d", tag, i), 32'(ser_last), 32'((i == 7) && !HAS_PAR));
            check($sformatf("%s busy%0d", tag, i), 32'({busy, s_ready}), 32'(2'b10));
            @(negedge clk);
        end
    endtask

    task automatic expect_par(input string tag, input logic par);
`ifdef PARITY_BIT_EN
        check({tag, " par valid"}, 32'(ser_valid), 1);
        check({tag, " par bit"}, 32'(ser_out), 32'(par));
        check({tag, " par last"}, 32'(ser_last), 1);
        @(negedge clk);
`else
        if (par === 1'bx) $display("note: %s parity unknown", tag);
`endif
    endtask

    task automatic expect_gap(input string tag);
        check({tag, " gap valid"}, 32'(ser_valid), 0);
        check({tag, " gap out"}, 32'(ser_out), 0);
        check({tag, " gap busy/ready"}, 32'({busy, s_ready}), 32'(2'b10));
        @(negedge clk);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " idle ready"}, 32'(s_ready), 1);
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle valid/last"}, 32'({ser_valid, ser_last}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lsb_seq;
        logic [7:0] dout_seq;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        l_s_valid = 1'b0;
        l_s_data  = 8'h00;
        cnt_clr   = 1'b1;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        check("rst ready", 32'(s_ready), 1);
        check("rst valid", 32'(ser_valid), 0);
        check("rst out", 32'(ser_out), 0);
        check("rst busy", 32'(busy), 0);
        check("rst last", 32'(ser_last), 0);
        rst = 1'b0;
        @(negedge clk);

        // 8'hA5 MSB first, one gap cycle, ready back in cycle 10.
        expect_idle("a5 pre");
        s_valid = 1'b1; s_data = 8'hA5; cnt_clr = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'h5A; cnt_clr = 1'b0;
        expect_data("a5", 8'b1010_0101);
        expect_par("a5", 1'b0);
        expect_gap("a5");
        expect_idle("a5 post");
        check("a5 length", 32'(n_valid), 32'(EXP_LEN));

        // s_valid held high across two words; s_data changes mid-word.
        s_valid = 1'b1; s_data = 8'h3C;
        @(negedge clk);
        s_data = 8'hC3;
        expect_data("3c", 8'b0011_1100);
        expect_par("3c", 1'b0);
        expect_gap("3c");
        expect_idle("c3 accept");
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'h0F;
        expect_data("c3", 8'b1100_0011);
        expect_par("c3", 1'b0);
        expect_gap("c3");
        expect_idle("c3 post");

        // Reset during the third bit of 8'hFF drops the word.
        s_valid = 1'b1; s_data = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ff bit%0d", i), 32'({ser_valid, ser_out, ser_last}), 32'(3'b110));
            if (i < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_idle("ff rst");
        check("ff rst out", 32'(ser_out), 0);
        @(negedge clk);
        expect_idle("ff rst+1");
        s_valid = 1'b1; s_data = 8'h01;
        @(negedge clk);
        s_valid = 1'b0;
        expect_data("01", 8'b0000_0001);
        expect_par("01", 1'b1);
        expect_gap("01");
        expect_idle("01 post");

        // Parity cases: 8'h07 (parity 1) and 8'h03 (parity 0).
        s_valid = 1'b1; s_data = 8'h07; cnt_clr = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; cnt_clr = 1'b0;
        expect_data("07", 8'b0000_0111);
        expect_par("07", 1'b1);
        expect_gap("07");
        expect_idle("07 post");
        check("07 length", 32'(n_valid), 32'(EXP_LEN));
        s_valid = 1'b1; s_data = 8'h03;
        @(negedge clk);
        s_valid = 1'b0;
        expect_data("03", 8'b0000_0011);
        expect_par("03", 1'b0);
        expect_gap("03");
        expect_idle("03 post");

        // LSB first, no gap, 8'h81 through the downstream toggle model.
        lsb_seq  = 8'b1000_0001;
        dout_seq = 8'b0111_1111;
        check("lsb pre ready", 32'(l_s_ready), 1);
        l_s_valid = 1'b1; l_s_data = 8'h81;
        @(negedge clk);
        l_s_valid = 1'b0; l_s_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb valid%0d", i), 32'(l_ser_valid), 1);
            check($sformatf("lsb bit%0d", i), 32'(l_ser_out), 32'(lsb_seq[7-i]));
            check($sformatf("lsb last%0d", i), 32'(l_ser_last), 32'((i == 7) && !HAS_PAR));
            check($sformatf("lsb dout%0d", i), 32'(ds_dout), 32'(dout_seq[7-i]));
            @(negedge clk);
        end
`ifdef PARITY_BIT_EN
        check("lsb par", 32'({l_ser_valid, l_ser_out, l_ser_last}), 32'(3'b101));
        @(negedge clk);
`endif
        check("lsb post ready", 32'(l_s_ready), 1);
        check("lsb post busy", 32'({l_busy, l_ser_valid}), 0);
        check("lsb post dout", 32'(ds_dout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bit_serializer
